nios_jtag_debug_scan_master: RTL and testbench

Scan initiator that drives the CPU's virtual-JTAG debug slave signals (tck, tdi, ir_in, state strobes) from the system clock domain and captures tdo. It performs one complete IR-select plus DR scan per command using a valid/ready handshake, and returns the captured DR contents. It is used for on-chip self-debug and as the bench driver for the debug module in simulation, where the virtual-JTAG primitive is stubbed.

---
 rtl/nios_jtag_debug_scan_master_if.sv | 28 ++
 rtl/nios_jtag_debug_scan_master.sv | 125 ++++++++++++
 tb/tb_nios_jtag_debug_scan_master.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/nios_jtag_debug_scan_master_if.sv
// Command/response handshake bundle for the debug scan master.
// master = command issuer, slave = scan engine.
interface nios_jtag_debug_scan_master_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_ir_en;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_data;
  logic [IR_WIDTH-1:0] rsp_ir_out;

  modport master (
    output cmd_valid, cmd_ir_en, cmd_ir, cmd_data,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out
  );

  modport slave (
    input  cmd_valid, cmd_ir_en, cmd_ir, cmd_data,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir_out
  );
endinterface

// File: rtl/nios_jtag_debug_scan_master.sv
// Virtual-JTAG scan initiator: optional IR update then one full DR scan.
// Define JTAG_SCAN_IR_CAPTURE_EN to sample vji_ir_out during UIR.
module nios_jtag_debug_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  nios_jtag_debug_scan_master_if.slave bus,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int PER = 2 * TCK_DIV;
  localparam int DW  = (PER > 1) ? $clog2(PER) : 1;
  localparam int BW  = $clog2(DR_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SDR,
    S_UDR, S_RTI, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       div_q;
  logic [BW-1:0]       bit_q;
  logic [DR_WIDTH-1:0] shift_q;
  logic [DR_WIDTH-1:0] cap_q;
  logic [IR_WIDTH-1:0] ir_q;

  logic active, accept, wrap, rise, last_bit;

  assign active   = (state_q != S_IDLE) &&
                    (state_q != S_DONE);
  assign accept   = bus.cmd_valid &&
                    (state_q == S_IDLE);
  assign wrap     = div_q == DW'(PER - 1);
  assign rise     = div_q == DW'(TCK_DIV - 1);
  assign last_bit = bit_q == BW'(DR_WIDTH - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept)
          state_d = bus.cmd_ir_en ? S_UIR : S_CDR;
      S_UIR: if (wrap) state_d = S_CDR;
      S_CDR: if (wrap) state_d = S_SDR;
      S_SDR: if (wrap && last_bit) state_d = S_UDR;
      S_UDR: if (wrap) state_d = S_RTI;
      S_RTI: if (wrap) state_d = S_DONE;
      S_DONE: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cap_q   <= '0;
      ir_q    <= '0;
    end else if (accept) begin
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= bus.cmd_data;
      if (bus.cmd_ir_en) ir_q <= bus.cmd_ir;
    end else if (active) begin
      div_q <= wrap ? '0 : div_q + 1'b1;
      // tdo is sampled as tck rises; tdi moves at period end
      if (vji_sdr && rise)
        cap_q <= {vji_tdo, cap_q[DR_WIDTH-1:1]};
      if (vji_sdr && wrap) begin
        shift_q <= shift_q >> 1;
        bit_q   <= bit_q + 1'b1;
      end
    end
  end

  assign vji_uir = state_q == S_UIR;
  assign vji_cdr = state_q == S_CDR;
  assign vji_sdr = state_q == S_SDR;
  assign vji_udr = state_q == S_UDR;
  assign vji_rti = state_q == S_RTI;

  assign vji_tck   = active && (div_q >= DW'(TCK_DIV));
  assign vji_tdi   = vji_sdr && shift_q[0];
  assign vji_ir_in = ir_q;

  assign bus.cmd_ready = state_q == S_IDLE;
  assign bus.rsp_valid = state_q == S_DONE;
  assign bus.rsp_data  = cap_q;

`ifdef JTAG_SCAN_IR_CAPTURE_EN
  logic [IR_WIDTH-1:0] ir_cap_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ir_cap_q <= '0;
    else if (vji_uir && rise)
      ir_cap_q <= vji_ir_out;
  end

  assign bus.rsp_ir_out = ir_cap_q;
`else
  logic unused_ir_out;
  assign unused_ir_out  = ^vji_ir_out;
  assign bus.rsp_ir_out = '0;
`endif

endmodule

// File: tb/tb_nios_jtag_debug_scan_master.sv
// Directed bench for the debug scan master.
// Two instances: default TCK_DIV=2 and TCK_DIV=1.
module tb_nios_jtag_debug_scan_master;

`ifdef JTAG_SCAN_IR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  nios_jtag_debug_scan_master_if #(.DR_WIDTH(38), .IR_WIDTH(2)) c0 ();
  nios_jtag_debug_scan_master_if #(.DR_WIDTH(38), .IR_WIDTH(2)) c1 ();

  logic       tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0;
  logic       tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;
  logic [1:0] ir_in0, ir_in1;
  logic [1:0] ir_out = 2'b00;
  int         tdo_mode = 0;

  assign tdo0 = (tdo_mode == 0) ? tdi0 : (tdo_mode == 1);
  assign tdo1 = (tdo_mode == 0) ? tdi1 : (tdo_mode == 1);

  nios_jtag_debug_scan_master u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(c0),
    .vji_tck(tck0), .vji_tdi(tdi0), .vji_tdo(tdo0),
    .vji_ir_in(ir_in0), .vji_ir_out(ir_out),
    .vji_uir(uir0), .vji_cdr(cdr0), .vji_sdr(sdr0),
    .vji_udr(udr0), .vji_rti(rti0)
  );

  nios_jtag_debug_scan_master #(.TCK_DIV(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(c1),
    .vji_tck(tck1), .vji_tdi(tdi1), .vji_tdo(tdo1),
    .vji_ir_in(ir_in1), .vji_ir_out(ir_out),
    .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1),
    .vji_udr(udr1), .vji_rti(rti1)
  );

  logic       mon_clr = 1'b1;
  logic       tck0_q = 1'b0, tck1_q = 1'b0;
  int         sdr_rises = 0, rises1 = 0, uir_cnt = 0;
  logic [1:0] uir_ir = 2'b00;

  always @(negedge clk) begin
    if (mon_clr) begin
      sdr_rises = 0;
      rises1    = 0;
      uir_cnt   = 0;
    end else begin
      if (tck0 && !tck0_q && sdr0) sdr_rises++;
      if (tck1 && !tck1_q) rises1++;
      if (uir0) begin
        uir_cnt++;
        uir_ir = ir_in0;
      end
    end
    tck0_q = tck0;
    tck1_q = tck1;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rv(input bit w);
    return w ? c1.rsp_valid : c0.rsp_valid;
  endfunction

  task automatic run_cmd(input bit w, input bit ir_en,
                         input logic [1:0] ir,
                         input logic [37:0] data,
                         output int lat);
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    if (w) begin
      c1.cmd_ir_en = ir_en; c1.cmd_ir = ir;
      c1.cmd_data = data;   c1.cmd_valid = 1'b1;
    end else begin
      c0.cmd_ir_en = ir_en; c0.cmd_ir = ir;
      c0.cmd_data = data;   c0.cmd_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    c0.cmd_valid = 1'b0;
    c1.cmd_valid = 1'b0;
    c0.cmd_data = '0;
    c1.cmd_data = '0;
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (rv(w)) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic finish_rsp(input bit w);
    if (w) c1.rsp_ready = 1'b1;
    else   c0.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    c0.rsp_ready = 1'b0;
    c1.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    int           bad;
    logic [37:0]  held;

    c0.cmd_valid = 0; c0.cmd_ir_en = 0; c0.cmd_ir = '0;
    c0.cmd_data = '0; c0.rsp_ready = 0;
    c1.cmd_valid = 0; c1.cmd_ir_en = 0; c1.cmd_ir = '0;
    c1.cmd_data = '0; c1.rsp_ready = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", c0.cmd_ready, 1);
    check("rst_tck", tck0, 0);
    check("rst_strobes", {uir0, cdr0, sdr0, udr0, rti0}, 0);
    check("rst_rsp_valid", c0.rsp_valid, 0);
    check("rst_rsp_data", c0.rsp_data, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // loopback, IR update
    tdo_mode = 0;
    ir_out = 2'b11;
    run_cmd(0, 1, 2'b10, 38'h2A_5555_AAAA, lat);
    check("lb_latency", lat, 168);
    check("lb_uir_cycles", uir_cnt, 4);
    check("lb_ir_in", uir_ir, 2'b10);
    check("lb_sdr_tck_rises", sdr_rises, 38);
    check("lb_rsp_data", c0.rsp_data, 38'h2A_5555_AAAA);
    check("lb_ir_out", c0.rsp_ir_out, CAP ? 2'b11 : 2'b00);

    // backpressure in DONE with a competing command
    held = c0.rsp_data;
    bad = 0;
    c0.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!c0.rsp_valid || c0.rsp_data !== held ||
          c0.cmd_ready || tck0)
        bad++;
    end
    check("bp_stable_cycles_bad", bad, 0);
    c0.cmd_valid = 1'b0;
    finish_rsp(0);
    check("bp_cmd_ready", c0.cmd_ready, 1);
    check("bp_rsp_valid", c0.rsp_valid, 0);
    @(posedge clk);
    #1;
    check("bp_still_idle", {c0.cmd_ready, uir0, cdr0}, 3'b100);

    // no IR update, tdo stuck high
    tdo_mode = 1;
    ir_out = 2'b00;
    run_cmd(0, 0, 2'b01, 38'h12_3456_7890, lat);
    check("noir_latency", lat, 164);
    check("noir_uir_cycles", uir_cnt, 0);
    check("noir_rsp_data", c0.rsp_data, 38'h3F_FFFF_FFFF);
    check("noir_ir_in", ir_in0, 2'b10);
    check("noir_ir_out_kept", c0.rsp_ir_out,
          CAP ? 2'b11 : 2'b00);
    finish_rsp(0);

    // TCK_DIV=1 instance, tdo low
    tdo_mode = 2;
    run_cmd(1, 1, 2'b01, 38'h15_0000_FFFF, lat);
    check("div1_latency", lat, 84);
    check("div1_rsp_data", c1.rsp_data, 0);
    check("div1_tck_rises", rises1, 42);
    finish_rsp(1);
    check("div1_cmd_ready", c1.cmd_ready, 1);

    // abort during SDR bit 20
    tdo_mode = 0;
    @(negedge clk);
    c0.cmd_ir_en = 1; c0.cmd_ir = 2'b11;
    c0.cmd_data = 38'h0F_F00F_F00F; c0.cmd_valid = 1;
    @(posedge clk);
    #1 c0.cmd_valid = 0;
    repeat (89) @(posedge clk);
    #2;
    check("abort_in_sdr", sdr0, 1);
    reset_n = 1'b0;
    #1;
    check("abort_cmd_ready", c0.cmd_ready, 1);
    check("abort_sdr", sdr0, 0);
    check("abort_tck", tck0, 0);
    check("abort_rsp_valid", c0.rsp_valid, 0);
    check("abort_ir_in", ir_in0, 0);
    check("abort_ir_out", c0.rsp_ir_out, 0);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_no_rsp", c0.rsp_valid, 0);

    ir_out = 2'b01;
    run_cmd(0, 1, 2'b01, 38'h00_C3A5_5A3C, lat);
    check("post_latency", lat, 168);
    check("post_rsp_data", c0.rsp_data, 38'h00_C3A5_5A3C);
    check("post_ir_out", c0.rsp_ir_out,
          CAP ? 2'b01 : 2'b00);
    finish_rsp(0);
    check("post_cmd_ready", c0.cmd_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
